color_classifier: RTL and testbench

COLOR_CLASSIFIER -- requirements
Module: color_classifier

---
 rtl/color_pkg.sv | 22 ++
 rtl/color_decide.sv | 31 +++
 rtl/color_classifier.sv | 124 ++++++++++++
 tb/tb_color_classifier.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// Shared color codes and FSM state encodings for the color classifier.
package color_pkg;

    typedef enum logic [2:0] {
        COL_W = 3'd0,
        COL_O = 3'd1,
        COL_G = 3'd2,
        COL_R = 3'd3,
        COL_B = 3'd4,
        COL_Y = 3'd5
    } color_e;

    typedef enum logic [1:0] {
        ST_ACCUM    = 2'd0,
        ST_CLASSIFY = 2'd1,
        ST_OUTPUT   = 2'd2
    } state_e;

    localparam int MATCH_W   = 4;
    localparam int MATCH_MAX = 15;

endpackage

// File: rtl/color_decide.sv
// Combinational decision tree mapping averaged (r,g,b) to a color code.
module color_decide
    import color_pkg::*;
#(
    parameter int          CW        = 8,
    parameter logic [CW-1:0] T_RED_HI  = 7,
    parameter logic [CW-1:0] T_BLUE_W  = 4,
    parameter logic [CW-1:0] T_GREEN_Y = 7,
    parameter logic [CW-1:0] T_RED_R   = 5,
    parameter logic [CW-1:0] T_GREEN_B = 5
) (
    input  logic [CW-1:0] r,
    input  logic [CW-1:0] g,
    input  logic [CW-1:0] b,
    output logic [2:0]    class_o
);

    always_comb begin
        class_o = COL_G;
        if (r >= T_RED_HI) begin
            if (b >= T_BLUE_W)       class_o = COL_W;
            else if (g >= T_GREEN_Y) class_o = COL_Y;
            else                     class_o = COL_O;
        end else if (r >= T_RED_R) begin
            class_o = COL_R;
        end else if (b > r && g < T_GREEN_B) begin
            class_o = COL_B;
        end
    end

endmodule

// File: rtl/color_classifier.sv
// Windowed RGB averaging color classifier with ready/valid in and out.
// Optional consecutive-window stability filter enabled by COLOR_STABLE_EN.
module color_classifier
    import color_pkg::*;
#(
    parameter int            CW         = 8,
    parameter int            LOG2_N     = 2,
    parameter int            STABLE_CNT = 3,
    parameter logic [CW-1:0] T_RED_HI   = 7,
    parameter logic [CW-1:0] T_BLUE_W   = 4,
    parameter logic [CW-1:0] T_GREEN_Y  = 7,
    parameter logic [CW-1:0] T_RED_R    = 5,
    parameter logic [CW-1:0] T_GREEN_B  = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          sample_valid,
    output logic          sample_ready,
    input  logic [CW-1:0] red,
    input  logic [CW-1:0] green,
    input  logic [CW-1:0] blue,
    output logic          color_valid,
    input  logic          color_ready,
    output logic [2:0]    color
);

    localparam int SW = CW + LOG2_N;
    // One extra bit so the counter can hold N itself for LOG2_N = 0.
    localparam int NW = LOG2_N + 1;
    localparam logic [NW-1:0] LAST = NW'((1 << LOG2_N) - 1);

    state_e          state_q, state_d;
    logic [SW-1:0]   sum_r_q, sum_g_q, sum_b_q;
    logic [NW-1:0]   cnt_q;
    logic [2:0]      color_q;
    logic [CW-1:0]   avg_r, avg_g, avg_b;
    logic [2:0]      cls;
    logic            accept;
    logic            to_out;

    assign accept = (state_q == ST_ACCUM) && sample_valid;
    assign avg_r  = CW'(sum_r_q >> LOG2_N);
    assign avg_g  = CW'(sum_g_q >> LOG2_N);
    assign avg_b  = CW'(sum_b_q >> LOG2_N);

    color_decide #(
        .CW(CW), .T_RED_HI(T_RED_HI), .T_BLUE_W(T_BLUE_W), .T_GREEN_Y(T_GREEN_Y),
        .T_RED_R(T_RED_R), .T_GREEN_B(T_GREEN_B)
    ) u_decide (
        .r(avg_r), .g(avg_g), .b(avg_b), .class_o(cls)
    );

`ifdef COLOR_STABLE_EN
    logic [MATCH_W-1:0] match_q, match_d;
    logic [2:0]         prev_q;

    always_comb begin
        match_d = MATCH_W'(1);
        if (cls == prev_q)
            match_d = (match_q == MATCH_W'(MATCH_MAX)) ? match_q : match_q + MATCH_W'(1);
    end

    assign to_out = (match_d >= MATCH_W'(STABLE_CNT));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            match_q <= '0;
            prev_q  <= COL_W;
        end else if (state_q == ST_CLASSIFY) begin
            match_q <= match_d;
            prev_q  <= cls;
        end else if (state_q == ST_OUTPUT && color_ready) begin
            match_q <= '0;
            prev_q  <= COL_W;
        end
    end
`else
    assign to_out = 1'b1;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_ACCUM;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM:    if (accept && cnt_q == LAST) state_d = ST_CLASSIFY;
            ST_CLASSIFY: state_d = to_out ? ST_OUTPUT : ST_ACCUM;
            ST_OUTPUT:   if (color_ready) state_d = ST_ACCUM;
            default:     state_d = ST_ACCUM;
        endcase
    end

    always_comb begin
        sample_ready = (state_q == ST_ACCUM);
        color_valid  = (state_q == ST_OUTPUT);
    end

    assign color = color_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum_r_q <= '0;
            sum_g_q <= '0;
            sum_b_q <= '0;
            cnt_q   <= '0;
            color_q <= COL_W;
        end else if (accept) begin
            sum_r_q <= sum_r_q + SW'(red);
            sum_g_q <= sum_g_q + SW'(green);
            sum_b_q <= sum_b_q + SW'(blue);
            cnt_q   <= cnt_q + NW'(1);
        end else if (state_q == ST_CLASSIFY) begin
            sum_r_q <= '0;
            sum_g_q <= '0;
            sum_b_q <= '0;
            cnt_q   <= '0;
            if (to_out) color_q <= cls;
        end
    end

endmodule

// File: tb/tb_color_classifier.sv
// Self-checking bench for color_classifier: table vectors, corner sequences, random windows.
module tb_color_classifier;

`ifdef COLOR_STABLE_EN
    localparam int SC = 3;
`else
    localparam int SC = 1;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sample_valid = 1'b0;
    logic       sample_ready;
    logic [7:0] red = '0, green = '0, blue = '0;
    logic       color_valid;
    logic       color_ready = 1'b0;
    logic [2:0] color;

    int checks = 0;
    int errors = 0;

    color_classifier dut (
        .clock(clock), .reset(reset),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .red(red), .green(green), .blue(blue),
        .color_valid(color_valid), .color_ready(color_ready), .color(color)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0][7:0] r;
        logic [3:0][7:0] g;
        logic [3:0][7:0] b;
        logic [2:0]      exp;
    } vec_t;

    vec_t vecs[7];
    int   hist[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference: average each channel over the window, then apply the class rules.
    function automatic int model(input logic [3:0][7:0] r, input logic [3:0][7:0] g,
                                 input logic [3:0][7:0] b);
        int ar = 0, ag = 0, ab = 0;
        for (int i = 0; i < 4; i++) begin
            ar += int'(r[i]); ag += int'(g[i]); ab += int'(b[i]);
        end
        ar = ar / 4; ag = ag / 4; ab = ab / 4;
        if (ar >= 7) return (ab >= 4) ? 0 : (ag >= 7) ? 5 : 1;
        if (ar >= 5) return 3;
        if (ab > ar && ag < 5) return 4;
        return 2;
    endfunction

    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input int gap);
        int t = 0;
        repeat (gap) @(posedge clock);
        @(negedge clock);
        while (!sample_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (!sample_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=0 expected=1");
        end
        red = r; green = g; blue = b; sample_valid = 1'b1;
        @(posedge clock); #1;
        sample_valid = 1'b0;
    endtask

    // Feeds one window, then checks the CLASSIFY cycle and the outcome of that window.
    task automatic run_window(input string nm, input logic [3:0][7:0] r,
                              input logic [3:0][7:0] g, input logic [3:0][7:0] b,
                              input int exp_cls, input bit exp_out, input int hold, input bit rgap);
        for (int i = 0; i < 4; i++)
            send(r[i], g[i], b[i], rgap ? $urandom_range(0, 2) : 0);
        chk({nm, "_classify_valid"}, int'(color_valid), 0);
        chk({nm, "_classify_ready"}, int'(sample_ready), 0);
        @(posedge clock); #1;
        chk({nm, "_valid"}, int'(color_valid), int'(exp_out));
        if (!exp_out) begin
            chk({nm, "_ready_back"}, int'(sample_ready), 1);
            return;
        end
        chk({nm, "_color"}, int'(color), exp_cls);
        for (int k = 0; k < hold; k++) begin
            red = 8'hff; green = 8'hff; blue = 8'hff; sample_valid = 1'b1;
            @(posedge clock); #1;
            chk({nm, "_hold_valid"}, int'(color_valid), 1);
            chk({nm, "_hold_color"}, int'(color), exp_cls);
            chk({nm, "_hold_ready"}, int'(sample_ready), 0);
        end
        color_ready = 1'b1;
        @(posedge clock); #1;
        color_ready = 1'b0;
        sample_valid = 1'b0;
        chk({nm, "_after_valid"}, int'(color_valid), 0);
        chk({nm, "_after_color"}, int'(color), exp_cls);
        chk({nm, "_after_ready"}, int'(sample_ready), 1);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("reset_valid", int'(color_valid), 0);
        chk("reset_color", int'(color), 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("reset_ready", int'(sample_ready), 1);
        hist.delete();
    endtask

    initial begin
        logic [3:0][7:0] rr, gg, bb;
        logic [3:0][7:0] y_r, y_g, y_b, g_r, g_g, g_b;
        int c;
        bit o;

        vecs[0] = '{r: {4{8'd8}},                g: {4{8'd2}}, b: {4{8'd1}}, exp: 3'd1};
        vecs[1] = '{r: {8'd8, 8'd6, 8'd8, 8'd6}, g: {4{8'd2}}, b: {4{8'd1}}, exp: 3'd1};
        vecs[2] = '{r: {8'd8, 8'd6, 8'd6, 8'd6}, g: {4{8'd2}}, b: {4{8'd1}}, exp: 3'd3};
        vecs[3] = '{r: {4{8'd9}},                g: {4{8'd9}}, b: {4{8'd5}}, exp: 3'd0};
        vecs[4] = '{r: {4{8'd9}},                g: {4{8'd9}}, b: {4{8'd2}}, exp: 3'd5};
        vecs[5] = '{r: {4{8'd1}},                g: {4{8'd2}}, b: {4{8'd6}}, exp: 3'd4};
        vecs[6] = '{r: {4{8'd3}},                g: {4{8'd9}}, b: {4{8'd3}}, exp: 3'd2};

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("init_ready", int'(sample_ready), 1);
        chk("init_valid", int'(color_valid), 0);
        chk("init_color", int'(color), 0);

        foreach (vecs[i])
            for (int k = 0; k < SC; k++)
                run_window($sformatf("vec%0d", i), vecs[i].r, vecs[i].g, vecs[i].b,
                           int'(vecs[i].exp), k == SC - 1, 0, 1'b0);

        for (int k = 0; k < SC; k++)
            run_window("backpressure", vecs[0].r, vecs[0].g, vecs[0].b, 1, k == SC - 1, 10, 1'b0);
        repeat (3) begin
            @(posedge clock); #1;
            chk("backpressure_single", int'(color_valid), 0);
        end

        // Partial window of large values must not leak into the next window.
        send(8'd15, 8'd15, 8'd15, 0);
        send(8'd15, 8'd15, 8'd15, 0);
        do_reset();
        for (int k = 0; k < SC; k++)
            run_window("reset_mid", vecs[5].r, vecs[5].g, vecs[5].b, 4, k == SC - 1, 0, 1'b0);

        // Reset while a color is pending drops it.
        for (int k = 0; k < SC; k++)
            for (int i = 0; i < 4; i++) send(8'd9, 8'd9, 8'd2, 0);
        @(posedge clock); #1;
        chk("pending_valid", int'(color_valid), 1);
        do_reset();
        repeat (2) begin
            @(posedge clock); #1;
            chk("pending_dropped", int'(color_valid), 0);
        end

`ifdef COLOR_STABLE_EN
        y_r = vecs[4].r; y_g = vecs[4].g; y_b = vecs[4].b;
        g_r = vecs[6].r; g_g = vecs[6].g; g_b = vecs[6].b;
        run_window("stab_y1", y_r, y_g, y_b, 5, 1'b0, 0, 1'b0);
        run_window("stab_y2", y_r, y_g, y_b, 5, 1'b0, 0, 1'b0);
        run_window("stab_g1", g_r, g_g, g_b, 2, 1'b0, 0, 1'b0);
        run_window("stab_g2", g_r, g_g, g_b, 2, 1'b0, 0, 1'b0);
        run_window("stab_g3", g_r, g_g, g_b, 2, 1'b1, 0, 1'b0);
`endif

        hist.delete();
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < 4; i++) begin
                rr[i] = 8'($urandom_range(0, 15));
                gg[i] = 8'($urandom_range(0, 15));
                bb[i] = 8'($urandom_range(0, 15));
            end
            c = model(rr, gg, bb);
            hist.push_back(c);
            o = 1'b0;
            if (hist.size() >= SC) begin
                o = 1'b1;
                for (int j = 1; j <= SC; j++)
                    if (hist[hist.size() - j] != c) o = 1'b0;
            end
            if (o) hist.delete();
            run_window($sformatf("rand%0d", n), rr, gg, bb, c, o, $urandom_range(0, 3), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
